// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: one job in, ROUND x COMPUTE_CYCLE bit-plane reads out (credit-metered vs cm_beat), one result back.
// First request 1 cycle after cmd; stalls on !rd_req_rdy or full credit. ACC_SEQ_PERF_EN adds perf counters.
module acc_seq_ctrl #(
  parameter int ADDR_W          = 16,
  parameter int COMPUTE_CYCLE   = 8,
  parameter int ROUND           = 128,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BIT_W = $clog2(COMPUTE_CYCLE),
  localparam int RND_W = $clog2(ROUND + 1),
  localparam int CRD_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [RND_W-1:0]  cmd_rounds,
  output logic              rd_req_vld,
  input  logic              rd_req_rdy,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [BIT_W-1:0]  rd_req_bit,
  output logic              rd_req_last,
  input  logic              cm_beat,
  input  logic              acc_vld,
  output logic              acc_rdy,
  input  logic              res_rdy,
  output logic              busy,
  output logic              done
`ifdef ACC_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_job_cyc
`endif
);

  localparam int TOT_W = RND_W + BIT_W;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, RESULT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [BIT_W-1:0]  bit_q;
  logic              last_q;
  logic [TOT_W-1:0]  idx_q, last_idx_q;
  logic [CRD_W-1:0]  credit_q;
  logic [RND_W-1:0]  eff_rounds;
  logic              cmd_hs, req_hs, beat_ok, credit_full;

  assign eff_rounds  = (cmd_rounds == '0) ? RND_W'(ROUND) : cmd_rounds;
  assign credit_full = (credit_q >= CRD_W'(MAX_OUTSTANDING));

  assign cmd_rdy     = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign acc_rdy     = (state_q == RESULT) & res_rdy;
  assign rd_req_vld  = (state_q == ISSUE) & ~credit_full;
  assign rd_req_addr = addr_q;
  assign rd_req_bit  = bit_q;
  assign rd_req_last = last_q;

  assign cmd_hs  = cmd_vld & cmd_rdy;
  assign req_hs  = rd_req_vld & rd_req_rdy;
  // A beat with nothing outstanding is stale (e.g. from an aborted job) and is dropped.
  assign beat_ok = cm_beat & (credit_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_vld)             state_d = ISSUE;
      ISSUE:   if (req_hs && last_q)    state_d = DRAIN;
      DRAIN:   if (credit_q == '0)      state_d = RESULT;
      RESULT:  if (acc_vld && acc_rdy)  state_d = DONE;
      DONE:                             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Linear request index: addr = base + idx, bit = CC-1 - (idx mod CC), so both just step by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      bit_q      <= '0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else if (cmd_hs) begin
      addr_q     <= cmd_base_addr;
      bit_q      <= BIT_W'(COMPUTE_CYCLE - 1);
      last_q     <= 1'b0;
      idx_q      <= '0;
      last_idx_q <= {eff_rounds, {BIT_W{1'b0}}} - TOT_W'(1);
    end else if (req_hs) begin
      addr_q     <= addr_q + ADDR_W'(1);
      bit_q      <= bit_q - BIT_W'(1);
      last_q     <= ((idx_q + TOT_W'(1)) == last_idx_q);
      idx_q      <= idx_q + TOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      case ({req_hs, beat_ok})
        2'b10:   credit_q <= credit_q + CRD_W'(1);
        2'b01:   credit_q <= credit_q - CRD_W'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

`ifdef ACC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_job_cyc   <= '0;
    end else if (cmd_hs) begin
      perf_stall_cnt <= '0;
      perf_job_cyc   <= '0;
    end else begin
      if ((state_q == ISSUE) && ((rd_req_vld && !rd_req_rdy) || credit_full) && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if ((state_q != IDLE) && (perf_job_cyc != '1))
        perf_job_cyc <= perf_job_cyc + 32'd1;
    end
  end
`endif

endmodule
